// File: rtl/multi_mode_ff_bank.sv
// rtl/multi_mode_ff_bank.sv - bank of WIDTH flip-flops selectable at run time as SR, JK, D or T
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   cfg_we    load cfg_mode into the mode register
//   cfg_mode  mode code: 00 SR, 01 JK, 10 D, 11 T
//   en        update enable; q holds when low
//   a         per channel S / J / D / T input
//   b         per channel R / K input (unused in D and T modes)
//   clr_err   clear sticky illegal flags and the event counter
//   q         stored state
//   qb        ~q (combinational)
//   mode      current mode register
//   illegal   sticky per-channel flag: S=R=1 seen in SR mode
//   err_cnt   saturating count of edges with at least one illegal channel

module multi_mode_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] events;
    logic             any_event;

    // Next-state per mode, evaluated with the mode register value before the edge,
    // so a cfg_we at the same edge does not affect this update.
    always_comb begin
        q_nxt = q;
        case (mode)
            // a==b holds (including the illegal 1/1 case); otherwise q follows a.
            MODE_SR: q_nxt = (q & ~(a ^ b)) | (a & ~b);
            MODE_JK: q_nxt = (a & ~q) | (~b & q);
            MODE_D:  q_nxt = a;
            MODE_T:  q_nxt = q ^ a;
            default: q_nxt = q;
        endcase
    end

    // Illegal events only exist on an enabled SR-mode edge.
    always_comb begin
        events = {WIDTH{1'b0}};
        if (en && (mode == MODE_SR)) begin
            events = a & b;
        end
    end

    assign any_event = |events;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= q_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_SR;
        end else if (cfg_we) begin
            mode <= cfg_mode;
        end
    end

    // A clear coinciding with new events leaves exactly the new events recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= {WIDTH{1'b0}};
        end else if (clr_err) begin
            illegal <= events;
        end else begin
            illegal <= illegal | events;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= {CNT_W{1'b0}};
        end else if (clr_err) begin
            err_cnt <= any_event ? CNT_ONE : {CNT_W{1'b0}};
        end else if (any_event && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb/tb_multi_mode_ff_bank.sv - directed self-checking bench for multi_mode_ff_bank

module tb_multi_mode_ff_bank;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_mode;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;

    logic [7:0] q0, qb0, ill0;
    logic [1:0] mode0;
    logic [7:0] cnt0;

    logic [7:0] q1, qb1, ill1;
    logic [1:0] mode1;
    logic [1:0] cnt1;

    int checks;
    int failures;

    multi_mode_ff_bank #(.WIDTH(8), .CNT_W(8), .RST_VAL(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .en(en),
        .a(a), .b(b), .clr_err(clr_err),
        .q(q0), .qb(qb0), .mode(mode0), .illegal(ill0), .err_cnt(cnt0)
    );

    multi_mode_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h00)) u_dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .en(en),
        .a(a), .b(b), .clr_err(clr_err),
        .q(q1), .qb(qb1), .mode(mode1), .illegal(ill1), .err_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] m, input logic e,
                         input logic [7:0] av, input logic [7:0] bv, input logic clr);
        cfg_we   = we;
        cfg_mode = m;
        en       = e;
        a        = av;
        b        = bv;
        clr_err  = clr;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Move away from reset state in D mode, then reset between edges.
        drive(1'b1, 2'b10, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        drive(1'b0, 2'b10, 1'b1, 8'h00, 8'h00, 1'b0);
        step();
        chk("pre_rst_q", q0, 8'h00);
        chk("pre_rst_mode", mode0, 2'b10);
        drive(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_q", q0, 8'hA5);
        chk("rst_qb", qb0, 8'h5A);
        chk("rst_mode", mode0, 2'b00);
        chk("rst_ill", ill0, 8'h00);
        chk("rst_cnt", cnt0, 8'h00);
        step();
        chk("rst_pending_mode", mode0, 2'b00);
        rst = 1'b0;

        // SR mode: reach q=0F, then per-channel mix.
        drive(1'b0, 2'b00, 1'b1, 8'h0F, 8'hF0, 1'b0);
        step();
        chk("sr_set_q", q0, 8'h0F);
        chk("sr_set_cnt", cnt0, 8'h00);
        drive(1'b0, 2'b00, 1'b1, 8'hF0, 8'h3C, 1'b0);
        step();
        chk("sr_mix_q", q0, 8'hC3);
        chk("sr_mix_ill", ill0, 8'h30);
        chk("sr_mix_cnt", cnt0, 8'h01);
        step();
        chk("sr_rep_q", q0, 8'hC3);
        chk("sr_rep_cnt", cnt0, 8'h02);
        chk("sr_rep_cnt_sat", cnt1, 2'd2);

        // Load JK with en: update uses old SR mode.
        drive(1'b1, 2'b01, 1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("ld_jk_q", q0, 8'hC3);
        chk("ld_jk_cnt", cnt0, 8'h03);
        chk("ld_jk_ill", ill0, 8'hFF);
        chk("ld_jk_mode", mode0, 2'b01);
        drive(1'b0, 2'b01, 1'b1, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("jk_tog_q", q0, 8'h3C);
        chk("jk_tog_cnt", cnt0, 8'h03);

        // Load D while JK resets all bits.
        drive(1'b1, 2'b10, 1'b1, 8'h00, 8'hFF, 1'b0);
        step();
        chk("ld_d_q", q0, 8'h00);
        drive(1'b0, 2'b10, 1'b1, 8'h3C, 8'h00, 1'b0);
        step();
        chk("d_q", q0, 8'h3C);

        // Load T while D captures 81.
        drive(1'b1, 2'b11, 1'b1, 8'h81, 8'h00, 1'b0);
        step();
        chk("ld_t_q", q0, 8'h81);
        chk("ld_t_qb", qb0, 8'h7E);
        drive(1'b0, 2'b11, 1'b1, 8'h01, 8'h00, 1'b0);
        step();
        chk("t_tog1", q0, 8'h80);
        step();
        chk("t_tog2", q0, 8'h81);
        step();
        chk("t_tog3", q0, 8'h80);

        // clr_err alone.
        drive(1'b0, 2'b11, 1'b0, 8'h00, 8'h00, 1'b1);
        step();
        chk("clr_ill", ill0, 8'h00);
        chk("clr_cnt", cnt0, 8'h00);
        chk("clr_cnt_sat", cnt1, 2'd0);

        // Back to SR, then saturation run.
        drive(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        chk("ld_sr_q", q0, 8'h80);
        drive(1'b0, 2'b00, 1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat_cnt_%0d", i), cnt1, (i < 3) ? (i + 1) : 3);
            chk($sformatf("wide_cnt_%0d", i), cnt0, i + 1);
        end
        chk("sat_q", q0, 8'h80);

        // clr_err with a channel-2 event.
        drive(1'b0, 2'b00, 1'b1, 8'h04, 8'h04, 1'b1);
        step();
        chk("clr_evt_ill", ill0, 8'h04);
        chk("clr_evt_cnt", cnt0, 8'h01);
        chk("clr_evt_cnt_sat", cnt1, 2'd1);
        chk("clr_evt_q", q0, 8'h80);

        // en=0 ignores everything.
        drive(1'b0, 2'b00, 1'b0, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("en0_q", q0, 8'h80);
        chk("en0_ill", ill0, 8'h04);
        chk("en0_cnt", cnt0, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_mode_ff_bank.md
# multi_mode_ff_bank

Parametrised bank of WIDTH independent storage bits sharing one clock, reset and run-time mode register. Each bit behaves as an SR, JK, D or T flip-flop depending on the selected mode, giving the design a configurable register primitive instead of fixed single-bit flip-flops. The SR "both active" condition is resolved deterministically rather than driven to high impedance. The condition is recorded per channel in sticky flags and in a saturating event counter for debug.

## Interface
- WIDTH, 8: number of flip-flop channels (≥1)
- CNT_W, 8: width of illegal-event counter (≥2)
- RST_VAL, {WIDTH{1'b0}}: per-channel value loaded into q on reset
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cfg_we  input  1  load cfg_mode into the mode register
- cfg_mode  input  2  mode code: 00 SR, 01 JK, 10 D, 11 T
- en  input  1  update enable; q holds when 0
- a  input  WIDTH  per channel: S, J, D or T input, depending on mode
- b  input  WIDTH  per channel: R in SR mode, K in JK mode; ignored in D and T modes
- clr_err  input  1  clear sticky flags and counter
- q  output  WIDTH  stored state
- qb  output  WIDTH  ~q, combinational
- mode  output  2  current mode register
- illegal  output  WIDTH  sticky per-channel flag: S=R=1 seen in SR mode
- err_cnt  output  CNT_W  count of cycles with any illegal channel, saturating

## Operation
- Reset (asynchronous, while rst=1):
  - q=RST_VAL
  - mode=2'b00
  - illegal=0
  - err_cnt=0
  - qb=~RST_VAL
- Per channel i, at a rising edge with en=1, using the mode register value *before* that edge:
  - SR mode:
    - a=0, b=0: hold
    - a=0, b=1: q=0
    - a=1, b=0: q=1
    - a=1, b=1: hold, and the event is flagged illegal for channel i
  - JK mode:
    - a=0, b=0: hold
    - a=0, b=1: q=0
    - a=1, b=0: q=1
    - a=1, b=1: q=~q
  - D mode: q=a.
  - T mode: q = q ^ a.
- en=0: all q hold. No illegal events are detected, regardless of a and b.
- Illegal event: en=1, mode=SR, and a[i]&b[i]=1.
- Sticky flags:
  - illegal[i] sets on an illegal event in channel i.
  - illegal[i] stays set until clr_err or reset.
- Counter:
  - err_cnt increments by exactly 1 per edge where at least one channel has an illegal event, independent of how many channels.
  - err_cnt saturates at 2^CNT_W−1 and does not wrap.
- clr_err and new illegal events at the same edge:
  - Flags become exactly the new event vector; all others are cleared.
  - err_cnt becomes 1 if any event occurred, else 0.
- cfg_we:
  - The mode register loads cfg_mode at the edge.
  - The new mode governs updates from the following edge onward.
  - cfg_we together with en: the data update at that edge uses the old mode.
- Mode changes never alter q by themselves.

## Timing
- Latency: a/b/en to q is one clock edge. cfg_mode to effective behaviour is one edge after the load edge.
- qb, mode, illegal and err_cnt are registered or directly derived. The only combinational path to an output is q→qb.
- Reset asserts asynchronously: q, mode, flags and counter change without a clock edge.
- Reset released: first functional update on the first rising edge with rst=0.
- Reset mid-operation (e.g. during a T-mode toggle sequence or a pending cfg_we): everything returns to reset values, and any pending mode load is discarded.
- No handshake. The block accepts an update every cycle en=1.

## Test plan
- Reset:
  - Stimulus: WIDTH=8, RST_VAL=8'hA5; assert rst asynchronously between edges.
  - Required: q=8'hA5 and qb=8'h5A immediately; mode=0, illegal=0, err_cnt=0.
- SR mode, per-channel mix:
  - Stimulus: from q=8'h0F, apply en=1, a=8'hF0, b=8'h3C.
  - Required: q=8'hC3; illegal=8'h30; err_cnt=1.
  - Stimulus: repeat the same inputs.
  - Required: q unchanged, err_cnt=2.
- Mode switch, JK then D then T:
  - Stimulus: at one edge, cfg_we with cfg_mode=01 and en=1, a=b=8'hFF.
  - Required: SR hold (old mode) and err_cnt increments.
  - Stimulus: next edge, same a/b.
  - Required: JK toggle, so q inverts.
  - Stimulus: load D, then a=8'h3C.
  - Required: q=8'h3C.
  - Stimulus: load T, then a=8'h01 for 3 edges.
  - Required: bit0 toggles 3 times.
- Counter saturation:
  - Stimulus: CNT_W=2; hold SR mode with a=b=1 for 5 edges.
  - Required: err_cnt sequence 1,2,3,3,3.
- clr_err interactions:
  - Stimulus: clr_err alone.
  - Required: flags=0, err_cnt=0.
  - Stimulus: clr_err with an illegal event on channel 2.
  - Required: illegal=8'h04, err_cnt=1.
  - Stimulus: en=0 with a=b=FF.
  - Required: no change to q, flags or err_cnt.
